ad9910_spi_arbiter: RTL and testbench

// - Shares the single AD9910 SPI driver (common SCLK, CSB/CSB2, SDIO/SDIO2) between NUM_REQ requesters
//   (UART command decoder, profile sequencer, ...).
// - Grants round-robin, hands one framed transfer to the driver, optionally pulses IO_UPDATE, then returns

---
 rtl/ad9910_spi_arbiter_pkg.sv | 22 ++
 rtl/ad9910_spi_arbiter_rr_arbiter.sv | 34 +++
 rtl/ad9910_spi_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ad9910_spi_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9910_spi_arbiter_pkg.sv
// Shared definitions for the AD9910 SPI arbiter: FSM states, chip-select
// encodings and instruction-byte layout.
package ad9910_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_CHECK = 3'd2,
    ST_WAIT  = 3'd3,
    ST_IOUPD = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] CHIP_DDS0  = 2'b01;
  localparam logic [1:0] CHIP_DDS1  = 2'b10;
  localparam logic [1:0] CHIP_BCAST = 2'b11;

  // Bit position of the R/W flag inside the 8-bit instruction byte.
  localparam int INSTR_READ_BIT = 7;
  localparam int MAX_FRAME_BITS = 72;

endpackage

// File: rtl/ad9910_spi_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// ptr (wrapping), returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default is how latches sneak in.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // NOTE: blocking assignments here on purpose -- later iterations must see
    // the updated 'valid' from earlier ones within the same evaluation.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    grant = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/ad9910_spi_arbiter.sv
// Shares one AD9910 SPI driver between NUM_REQ requesters: round-robin grant,
// frame validation, driver handshake with timeout, optional IO_UPDATE pulse.
module ad9910_spi_arbiter
  import ad9910_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 72,
  parameter int LEN_WIDTH      = 7,
  parameter int IOUPD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            CLK100MHZ,
  input  logic                            RSTN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*2-1:0]            req_chip,
  input  logic [NUM_REQ-1:0]              req_ioupd,
  output logic [NUM_REQ-1:0]              resp_done,
  output logic                            resp_err,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            drv_start,
  output logic [DATA_WIDTH-1:0]           drv_data,
  output logic [LEN_WIDTH-1:0]            drv_len,
  output logic [1:0]                      drv_cs_sel,
  input  logic                            drv_busy,
  input  logic                            drv_done,
  input  logic [DATA_WIDTH-1:0]           drv_rdata,
  output logic                            io_update,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + IOUPD_CYCLES + 1);

  state_t                 state, state_nx;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [1:0]             sel_chip;
  logic                   sel_ioupd;
  logic                   lat_ioupd;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [CNT_W-1:0]       cnt;
  logic                   is_read;
  logic                   reject;
  logic                   timeout_hit;
  logic [DATA_WIDTH-1:0]  len_mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_data  = '0;
    sel_len   = '0;
    sel_chip  = '0;
    sel_ioupd = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        sel_chip  = req_chip[i*2 +: 2];
        sel_ioupd = req_ioupd[i];
      end
    end
  end

  // Frame checks run on the latched copy that is already driving the driver.
  assign is_read = drv_data[DATA_WIDTH-8+INSTR_READ_BIT];
  assign reject  = (drv_len == '0) || (int'(drv_len) > DATA_WIDTH) ||
                   (drv_cs_sel == 2'b00) || (drv_cs_sel == CHIP_BCAST && is_read);

  // cnt is 1 in the first WAIT cycle, so leaving at TIMEOUT_CYCLES-1 puts the
  // error response exactly TIMEOUT_CYCLES clocks after drv_start.
  assign timeout_hit = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    if (int'(drv_len) >= DATA_WIDTH) len_mask = '1;
    else                             len_mask = (DATA_WIDTH'(1) << drv_len) - DATA_WIDTH'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (|req_valid) state_nx = ST_GRANT;
      ST_GRANT: state_nx = arb_valid ? ST_CHECK : ST_IDLE;
      ST_CHECK: begin
        if (reject)         state_nx = ST_RESP;
        else if (!drv_busy) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (drv_done)         state_nx = lat_ioupd ? ST_IOUPD : ST_RESP;
        else if (timeout_hit) state_nx = ST_RESP;
      end
      ST_IOUPD: if (cnt == CNT_W'(IOUPD_CYCLES - 1)) state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // NOTE: only control/datapath registers exist here (no arrays), and every
  // one is cleared asynchronously so an aborted transfer leaves nothing behind.
  always_ff @(posedge CLK100MHZ or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      // ptr holds the last winner; the top index makes requester 0 first.
      ptr        <= IDX_W'(NUM_REQ - 1);
      grant_id   <= '0;
      drv_data   <= '0;
      drv_len    <= '0;
      drv_cs_sel <= '0;
      lat_ioupd  <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt        <= '0;
      io_update  <= 1'b0;
    end else begin
      state     <= state_nx;
      io_update <= (state_nx == ST_IOUPD);
      case (state)
        ST_GRANT: if (arb_valid) begin
          ptr        <= arb_idx;
          grant_id   <= arb_idx;
          drv_data   <= sel_data;
          drv_len    <= sel_len;
          drv_cs_sel <= sel_chip;
          lat_ioupd  <= sel_ioupd;
          err_q      <= 1'b0;
          rdata_q    <= '0;
        end
        ST_CHECK: begin
          if (reject) err_q <= 1'b1;
          cnt <= CNT_W'(1);
        end
        ST_WAIT: begin
          if (drv_done) begin
            rdata_q <= is_read ? (drv_rdata & len_mask) : '0;
            cnt     <= '0;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_IOUPD: cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign req_ready = (state == ST_GRANT) ? arb_grant : '0;
  assign drv_start = (state == ST_CHECK) && !reject && !drv_busy;
  assign resp_done = (state == ST_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign resp_err  = (state == ST_RESP) && err_q;
  assign resp_data = (state == ST_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_ad9910_spi_arbiter.sv
// Directed bench for ad9910_spi_arbiter with a behavioural SPI driver model
// and an event monitor that timestamps handshake strobes.
module tb_ad9910_spi_arbiter;

  localparam int NR  = 2;
  localparam int DW  = 72;
  localparam int LW  = 7;
  localparam int IOC = 4;
  localparam int TMO = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid, req_ready, req_ioupd, resp_done;
  logic [NR*DW-1:0]  req_data;
  logic [NR*LW-1:0]  req_len;
  logic [NR*2-1:0]   req_chip;
  logic              resp_err, drv_start, drv_busy, drv_done, io_update, busy;
  logic [DW-1:0]     resp_data, drv_data, drv_rdata;
  logic [LW-1:0]     drv_len;
  logic [1:0]        drv_cs_sel;
  logic [0:0]        grant_id;

  ad9910_spi_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .IOUPD_CYCLES(IOC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK100MHZ(clk), .RSTN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_len(req_len), .req_chip(req_chip), .req_ioupd(req_ioupd),
    .resp_done(resp_done), .resp_err(resp_err), .resp_data(resp_data),
    .drv_start(drv_start), .drv_data(drv_data), .drv_len(drv_len),
    .drv_cs_sel(drv_cs_sel), .drv_busy(drv_busy), .drv_done(drv_done),
    .drv_rdata(drv_rdata), .io_update(io_update), .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver model: busy from the clock after drv_start, done after drv_lat clocks.
  int          drv_lat = 3;
  bit          drv_hang = 1'b0;
  logic [DW-1:0] drv_rd_val = '0;

  initial begin
    drv_busy = 1'b0; drv_done = 1'b0; drv_rdata = '0;
    forever begin
      @(negedge clk);
      if (drv_start && !drv_hang) begin
        @(posedge clk); #1 drv_busy = 1'b1;
        repeat (drv_lat) @(posedge clk);
        #1 drv_done = 1'b1; drv_rdata = drv_rd_val;
        @(posedge clk); #1 drv_done = 1'b0; drv_busy = 1'b0; drv_rdata = '0;
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  int            start_cnt = 0, overlap = 0, io_cnt = 0, io_first = 0, resp_cnt = 0;
  int            t_start = 0, t_done = 0, t_ready = 0;
  bit            outstanding = 1'b0;
  int            gq[$];
  logic [DW-1:0] st_data;
  logic [LW-1:0] st_len;
  logic [1:0]    st_cs;

  always @(negedge clk) begin
    if (!rst_n) outstanding = 1'b0;
    else begin
      if (drv_start) begin
        start_cnt++;
        if (outstanding) overlap++;
        outstanding = 1'b1;
        t_start = cyc; st_data = drv_data; st_len = drv_len; st_cs = drv_cs_sel;
      end
      if (drv_done) begin outstanding = 1'b0; t_done = cyc; end
      if (io_update) begin
        if (io_cnt == 0) io_first = cyc;
        io_cnt++;
      end
      if (|req_ready) begin t_ready = cyc; gq.push_back(req_ready[1] ? 1 : 0); end
      if (|resp_done) begin outstanding = 1'b0; resp_cnt++; end
    end
  end

  logic [DW-1:0] r_data;
  logic          r_err;
  logic [NR-1:0] r_done;
  int            t_resp;

  task automatic wait_ready(input int r);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready[r]) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (|resp_done) begin
        r_done = resp_done; r_err = resp_err; r_data = resp_data; t_resp = cyc;
        return;
      end
    end
    check("resp_timeout", 0, 1);
  endtask

  task automatic send(input int r, input logic [DW-1:0] d, input logic [LW-1:0] l,
                      input logic [1:0] c, input logic io);
    @(posedge clk); #1;
    io_cnt = 0;
    req_data[r*DW +: DW] = d;
    req_len[r*LW +: LW]  = l;
    req_chip[r*2 +: 2]   = c;
    req_ioupd[r]         = io;
    req_valid[r]         = 1'b1;
    wait_ready(r);
    @(posedge clk); #1 req_valid[r] = 1'b0;
    wait_resp();
  endtask

  localparam logic [DW-1:0] WR_FRAME = 72'h0E_3FFF_0000_1999_999A;
  localparam logic [DW-1:0] RD_FRAME = 72'h81_0000_0000_0000_0000;
  localparam logic [DW-1:0] WR_SHORT = 72'h01_0203_0000_0000_0000;

  logic [DW-1:0] rj_data[4] = '{WR_FRAME, WR_FRAME, WR_SHORT, RD_FRAME};
  logic [LW-1:0] rj_len[4]  = '{7'd0, 7'd80, 7'd24, 7'd40};
  logic [1:0]    rj_chip[4] = '{2'b01, 2'b01, 2'b00, 2'b11};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nresp;
    int s0;
    int rc;
    req_data  = '0; req_len = '0; req_chip = '0; req_ioupd = '0;
    // Both requesters valid from reset for the contention run.
    req_data[0*DW +: DW] = WR_SHORT; req_len[0*LW +: LW] = 7'd24; req_chip[1:0] = 2'b01;
    req_data[1*DW +: DW] = WR_SHORT; req_len[1*LW +: LW] = 7'd24; req_chip[3:2] = 2'b10;
    req_valid = 2'b11;
    drv_lat = 2;

    repeat (3) @(negedge clk);
    check("rst_busy",      busy,      0);
    check("rst_io_update", io_update, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_done", resp_done, 0);
    check("rst_drv_start", drv_start, 0);
    check("rst_grant_id",  grant_id,  0);
    rst_n = 1'b1;

    // Contention: four back-to-back transfers while both stay valid.
    nresp = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (|resp_done) begin
        nresp++;
        if (nresp == 4) begin req_valid = '0; break; end
      end
    end
    check("rr_count", gq.size(), 4);
    check("rr_grant0", gq[0], 0);
    check("rr_grant1", gq[1], 1);
    check("rr_grant2", gq[2], 0);
    check("rr_grant3", gq[3], 1);
    check("rr_starts", start_cnt, 4);
    check("rr_overlap", overlap, 0);

    // Single write with IO_UPDATE.
    drv_lat = 3; drv_rd_val = 72'hABCD;
    send(0, WR_FRAME, 7'd72, 2'b01, 1'b1);
    check("wr_start_lat", t_start - t_ready, 1);
    check("wr_io_len",    io_cnt, IOC);
    check("wr_io_first",  io_first, t_done + 1);
    check("wr_resp_lat",  t_resp, t_done + IOC + 1);
    check("wr_done",      r_done, 2'b01);
    check("wr_err",       r_err, 0);
    check("wr_rdata",     r_data, 0);
    check("wr_drv_data",  st_data, WR_FRAME);
    check("wr_drv_len",   st_len, 72);
    check("wr_drv_cs",    st_cs, 2'b01);

    // Read from DDS1.
    drv_rd_val = 72'h00_0000_0002_08;
    send(1, RD_FRAME, 7'd40, 2'b10, 1'b0);
    check("rd_data",     r_data, 72'h208);
    check("rd_cs",       st_cs, 2'b10);
    check("rd_io",       io_cnt, 0);
    check("rd_done",     r_done, 2'b10);
    check("rd_err",      r_err, 0);
    check("rd_resp_lat", t_resp, t_done + 1);

    // Rejected frames never reach the driver.
    for (int i = 0; i < 4; i++) begin
      s0 = start_cnt;
      send(0, rj_data[i], rj_len[i], rj_chip[i], 1'b1);
      check($sformatf("rej%0d_err", i),     r_err, 1);
      check($sformatf("rej%0d_done", i),    r_done, 2'b01);
      check($sformatf("rej%0d_nostart", i), start_cnt, s0);
      check($sformatf("rej%0d_io", i),      io_cnt, 0);
    end

    // Timeout with a silent driver, then normal service resumes.
    drv_hang = 1'b1;
    send(0, WR_SHORT, 7'd24, 2'b01, 1'b0);
    check("to_err", r_err, 1);
    check("to_lat", t_resp - t_start, TMO);
    check("to_io",  io_cnt, 0);
    drv_hang = 1'b0; drv_lat = 2;
    send(1, WR_SHORT, 7'd24, 2'b10, 1'b0);
    check("nx_err",  r_err, 0);
    check("nx_done", r_done, 2'b10);
    check("nx_lat",  t_resp, t_done + 1);

    // Reset in the second IO_UPDATE clock.
    @(posedge clk); #1;
    io_cnt = 0;
    req_data[0*DW +: DW] = WR_FRAME; req_len[0*LW +: LW] = 7'd72;
    req_chip[1:0] = 2'b01; req_ioupd[0] = 1'b1; req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1 req_valid = 2'b11; req_ioupd = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io_update) break;
    end
    rc = resp_cnt;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("ar_io_update", io_update, 0);
    check("ar_busy",      busy, 0);
    check("ar_req_ready", req_ready, 0);
    check("ar_resp_done", resp_done, 0);
    check("ar_drv_start", drv_start, 0);
    repeat (2) @(negedge clk);
    check("ar_io_cnt", io_cnt, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (|req_ready) break;
    end
    check("ar_first_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    wait_resp();
    check("ar_new_done", r_done, 2'b01);
    repeat (2) @(negedge clk);
    check("ar_resp_cnt", resp_cnt, rc + 1);
    check("all_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
